// File: rtl/opl3_pkg.sv
// Shared types and defaults for the OPL3 slot sequencer: frame geometry,
// slot index types and the sequencer FSM state encoding.
package opl3_pkg;

  localparam int NUM_BANKS              = 2;
  localparam int NUM_OPERATORS_PER_BANK = 18;
  localparam int CLK_DIV_DEFAULT        = 256;
  localparam int SLOT_CYCLES_DEFAULT    = 4;
  localparam int PIPELINE_DEPTH_DEFAULT = 6;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int BANK_NUM_W     = min1_clog2(NUM_BANKS);
  localparam int OPERATOR_NUM_W = min1_clog2(NUM_OPERATORS_PER_BANK);

  typedef logic [BANK_NUM_W-1:0]     bank_num_t;
  typedef logic [OPERATOR_NUM_W-1:0] operator_num_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2,
    DRAIN = 2'd3
  } seq_state_t;

endpackage

// File: rtl/opl3_sample_tick_gen.sv
// Sample-rate divider: emits a one-cycle sample_clk_en every CLK_DIV enabled
// cycles. The count parks at its terminal value on reset so the first tick
// follows the first enabled cycle; a low enable freezes the count.
module opl3_sample_tick_gen #(
  parameter int CLK_DIV = opl3_pkg::CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic sample_clk_en
);

  localparam int            DW       = opl3_pkg::min1_clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt_r;

  // Free-running divider with registered tick pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt_r     <= DIV_LAST;
      sample_clk_en <= 1'b0;
    end else if (enable) begin
      if (div_cnt_r == DIV_LAST) begin
        div_cnt_r     <= '0;
        sample_clk_en <= 1'b1;
      end else begin
        div_cnt_r     <= div_cnt_r + DW'(1);
        sample_clk_en <= 1'b0;
      end
    end else begin
      sample_clk_en <= 1'b0;
    end
  end

endmodule

// File: rtl/opl3_slot_sequencer.sv
// OPL3 slot sequencer: on each sample tick issues every (bank, operator) slot
// into the shared operator pipeline, one slot every SLOT_CYCLES cycles, then
// waits PIPELINE_DEPTH cycles for the last slot to drain and pulses frame_done.
// Optional build macro OPL3_FRAME_COUNTER_EN adds a 16-bit wrapping count of
// completed frames on port frame_count.
module opl3_slot_sequencer #(
  parameter int CLK_DIV        = opl3_pkg::CLK_DIV_DEFAULT,
  parameter int NUM_BANKS      = opl3_pkg::NUM_BANKS,
  parameter int NUM_OPS        = opl3_pkg::NUM_OPERATORS_PER_BANK,
  parameter int SLOT_CYCLES    = opl3_pkg::SLOT_CYCLES_DEFAULT,
  parameter int PIPELINE_DEPTH = opl3_pkg::PIPELINE_DEPTH_DEFAULT,
  localparam int BW = opl3_pkg::min1_clog2(NUM_BANKS),
  localparam int OW = opl3_pkg::min1_clog2(NUM_OPS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  output logic          sample_clk_en,
  output logic          op_issue,
  output logic [BW-1:0] bank_num,
  output logic [OW-1:0] op_num,
  output logic          frame_last,
  output logic          frame_done,
  output logic          busy,
  output logic          overrun
`ifdef OPL3_FRAME_COUNTER_EN
  ,
  output logic [15:0]   frame_count
`endif
);

  import opl3_pkg::*;

  localparam int            GW          = min1_clog2(SLOT_CYCLES);
  localparam int            RW          = min1_clog2(PIPELINE_DEPTH);
  localparam logic [BW-1:0] BANK_LAST   = BW'(NUM_BANKS - 1);
  localparam logic [OW-1:0] OP_LAST     = OW'(NUM_OPS - 1);
  // GAP covers SLOT_CYCLES-1 cycles; the next issue is launched from its last one.
  localparam logic [GW-1:0] GAP_LAST    = GW'((SLOT_CYCLES > 1) ? SLOT_CYCLES - 2 : 0);
  // DRAIN covers PIPELINE_DEPTH cycles; its last one carries frame_done.
  localparam logic [RW-1:0] DRAIN_LAST  = RW'(PIPELINE_DEPTH - 1);
  localparam logic [RW-1:0] DRAIN_PRE   = RW'((PIPELINE_DEPTH > 1) ? PIPELINE_DEPTH - 2 : 0);
  localparam logic          SINGLE_SLOT = ((NUM_BANKS * NUM_OPS) == 1);
  localparam logic          DONE_ENTRY  = (PIPELINE_DEPTH == 1);

  seq_state_t    state_r;
  logic [GW-1:0] gap_cnt_r;
  logic [RW-1:0] drain_cnt_r;
  logic [BW-1:0] nxt_bank_s;
  logic [OW-1:0] nxt_op_s;
  logic          nxt_last_s;

  opl3_sample_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .sample_clk_en (sample_clk_en)
  );

  // Slot that follows the one currently on bank_num/op_num, in issue order.
  always_comb begin
    nxt_bank_s = bank_num;
    nxt_op_s   = op_num;
    if (op_num == OP_LAST) begin
      nxt_op_s   = '0;
      nxt_bank_s = bank_num + BW'(1);
    end else begin
      nxt_op_s   = op_num + OW'(1);
      nxt_bank_s = bank_num;
    end
    nxt_last_s = (nxt_bank_s == BANK_LAST) && (nxt_op_s == OP_LAST);
  end

  // Frame FSM: issue / gap / drain sequencing with registered strobes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      gap_cnt_r   <= '0;
      drain_cnt_r <= '0;
      op_issue    <= 1'b0;
      frame_last  <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
      bank_num    <= '0;
      op_num      <= '0;
      overrun     <= 1'b0;
    end else begin
      op_issue   <= 1'b0;
      frame_last <= 1'b0;
      frame_done <= 1'b0;

      // A tick that lands inside a frame is dropped but remembered.
      if (sample_clk_en && busy) begin
        overrun <= 1'b1;
      end

      case (state_r)
        IDLE: begin
          if (sample_clk_en) begin
            state_r    <= ISSUE;
            op_issue   <= 1'b1;
            frame_last <= SINGLE_SLOT;
            busy       <= 1'b1;
            bank_num   <= '0;
            op_num     <= '0;
          end
        end

        ISSUE: begin
          if (frame_last) begin
            state_r     <= DRAIN;
            drain_cnt_r <= '0;
            frame_done  <= DONE_ENTRY;
          end else if (SLOT_CYCLES == 1) begin
            op_issue   <= 1'b1;
            bank_num   <= nxt_bank_s;
            op_num     <= nxt_op_s;
            frame_last <= nxt_last_s;
          end else begin
            state_r   <= GAP;
            gap_cnt_r <= '0;
          end
        end

        GAP: begin
          if (gap_cnt_r == GAP_LAST) begin
            state_r    <= ISSUE;
            op_issue   <= 1'b1;
            bank_num   <= nxt_bank_s;
            op_num     <= nxt_op_s;
            frame_last <= nxt_last_s;
          end else begin
            gap_cnt_r <= gap_cnt_r + GW'(1);
          end
        end

        DRAIN: begin
          if (drain_cnt_r == DRAIN_LAST) begin
            state_r  <= IDLE;
            busy     <= 1'b0;
            bank_num <= '0;
            op_num   <= '0;
          end else begin
            drain_cnt_r <= drain_cnt_r + RW'(1);
            frame_done  <= (drain_cnt_r == DRAIN_PRE);
          end
        end

        default: begin
          state_r  <= IDLE;
          busy     <= 1'b0;
          bank_num <= '0;
          op_num   <= '0;
        end
      endcase
    end
  end

`ifdef OPL3_FRAME_COUNTER_EN
  // Count completed frames; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frame_count <= 16'd0;
    end else if (frame_done) begin
      frame_count <= frame_count + 16'd1;
    end else begin
      frame_count <= frame_count;
    end
  end
`endif

endmodule

// File: tb/tb_opl3_slot_sequencer.sv
// Self-checking bench for opl3_slot_sequencer. Expected outputs come from a
// frame-level model: a frame is "a tick at cycle T", and every output in a
// later cycle is derived arithmetically from the offset d = cycle - T.
module tb_opl3_slot_sequencer;

  localparam int CLK_DIV  = 128;
  localparam int NB       = 2;
  localparam int NO       = 18;
  localparam int SC       = 4;
  localparam int PD       = 6;
  localparam int NS       = NB * NO;
  localparam int DONE_OFF = 1 + (NS - 1) * SC + PD;
  localparam int BW       = 1;
  localparam int OW       = 5;
  localparam int VW       = 6 + BW + OW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          sample_clk_en, op_issue, frame_last, frame_done, busy, overrun;
  logic [BW-1:0] bank_num;
  logic [OW-1:0] op_num;
`ifdef OPL3_FRAME_COUNTER_EN
  logic [15:0]   frame_count;
`endif

  int checks = 0;
  int fails  = 0;

  // Reference model state
  int m_cyc    = 0;
  int m_ft     = 0;
  int m_div    = CLK_DIV - 1;
  int m_frames = 0;
  bit m_tick   = 1'b0;
  bit m_active = 1'b0;
  bit m_ovr    = 1'b0;

  opl3_slot_sequencer #(
    .CLK_DIV        (CLK_DIV),
    .NUM_BANKS      (NB),
    .NUM_OPS        (NO),
    .SLOT_CYCLES    (SC),
    .PIPELINE_DEPTH (PD)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .sample_clk_en (sample_clk_en),
    .op_issue      (op_issue),
    .bank_num      (bank_num),
    .op_num        (op_num),
    .frame_last    (frame_last),
    .frame_done    (frame_done),
    .busy          (busy),
    .overrun       (overrun)
`ifdef OPL3_FRAME_COUNTER_EN
    ,
    .frame_count   (frame_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] act_v();
    return {sample_clk_en, op_issue, bank_num, op_num, frame_last, frame_done, busy, overrun};
  endfunction

  // Expected outputs in the current cycle, from the frame offset.
  function automatic logic [VW-1:0] model_v();
    int d, k, kk;
    logic iss, last, done, bsy;
    logic [BW-1:0] b;
    logic [OW-1:0] o;
    iss = 1'b0; last = 1'b0; done = 1'b0; bsy = 1'b0; b = '0; o = '0;
    d = m_cyc - m_ft;
    if (m_active && d >= 1) begin
      bsy  = 1'b1;
      k    = (d - 1) / SC;
      kk   = (k < NS) ? k : NS - 1;
      iss  = ((d - 1) % SC == 0) && (k < NS);
      last = iss && (k == NS - 1);
      done = (d == DONE_OFF);
      b    = BW'(kk / NO);
      o    = OW'(kk % NO);
    end
    return {m_tick, iss, b, o, last, done, bsy, m_ovr};
  endfunction

  // Advance the model across one rising edge with the inputs it sampled.
  task automatic model_edge(input logic rn, input logic en);
    int prev;
    bit busy_prev;
    prev  = m_cyc;
    m_cyc = m_cyc + 1;
    if (!rn) begin
      m_div = CLK_DIV - 1; m_tick = 1'b0; m_active = 1'b0; m_ovr = 1'b0; m_frames = 0;
    end else begin
      busy_prev = m_active && (prev - m_ft >= 1);
      if (m_active && (prev - m_ft == DONE_OFF)) begin
        m_active = 1'b0;
        m_frames = m_frames + 1;
      end
      if (m_tick) begin
        if (busy_prev) m_ovr = 1'b1;
        else begin
          m_active = 1'b1;
          m_ft     = prev;
        end
      end
      if (en) begin
        if (m_div == CLK_DIV - 1) begin m_div = 0; m_tick = 1'b1; end
        else begin m_div = m_div + 1; m_tick = 1'b0; end
      end else begin
        m_tick = 1'b0;
      end
    end
  endtask

  task automatic step(input logic en, input logic rn);
    enable  = en;
    reset_n = rn;
    @(posedge clk);
    model_edge(rn, en);
    #1;
  endtask

  int t_frame;

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      checks++;
      if (act_v() !== '0) begin
        fails++; $display("FAIL reset_outputs: got %h expected 0", act_v());
      end
    end
    step(1'b1, 1'b1);
    checks++;
    if (sample_clk_en !== 1'b1) begin
      fails++; $display("FAIL first_tick: sample_clk_en got %b expected 1", sample_clk_en);
    end
    t_frame = m_cyc;
  endtask

  task automatic test_full_frame();
    int n_iss, last_d, done_d;
    n_iss = 0; last_d = -1; done_d = -1;
    for (int d = 1; d <= DONE_OFF + 1; d++) begin
      step(1'b1, 1'b1);
      checks++;
      if (act_v() !== model_v()) begin
        fails++; $display("FAIL frame_cycle d=%0d: got %h expected %h", d, act_v(), model_v());
      end
      checks++;
      if (busy !== (d <= 147)) begin
        fails++; $display("FAIL busy_window d=%0d: got %b", d, busy);
      end
      if (op_issue === 1'b1) begin
        checks++;
        if (bank_num !== BW'(n_iss / NO) || op_num !== OW'(n_iss % NO) || d != 1 + n_iss * 4) begin
          fails++; $display("FAIL slot_order d=%0d: got (%0d,%0d) expected (%0d,%0d) at d=%0d",
                            d, bank_num, op_num, n_iss / NO, n_iss % NO, 1 + n_iss * 4);
        end
        n_iss++;
      end
      if (frame_last === 1'b1) last_d = d;
      if (frame_done === 1'b1) done_d = d;
      if (d == CLK_DIV) begin
        checks++;
        if (sample_clk_en !== 1'b1) begin
          fails++; $display("FAIL tick_period: sample_clk_en got %b expected 1", sample_clk_en);
        end
      end
    end
    checks++;
    if (n_iss != 36 || last_d != 141 || done_d != 147) begin
      fails++; $display("FAIL frame_shape: issues=%0d last=%0d done=%0d expected 36/141/147",
                        n_iss, last_d, done_d);
    end
  endtask

  task automatic test_overrun();
    int found;
    found = 0;
    checks++;
    if (overrun !== 1'b1) begin
      fails++; $display("FAIL overrun_set: got %b expected 1", overrun);
    end
    for (int i = 0; i < 2 * CLK_DIV && found == 0; i++) begin
      step(1'b1, 1'b1);
      checks++;
      if (act_v() !== model_v()) begin
        fails++; $display("FAIL overrun_cycle: got %h expected %h", act_v(), model_v());
      end
      if (op_issue === 1'b1) found = m_cyc - t_frame;
    end
    checks++;
    if (found != 257 || overrun !== 1'b1) begin
      fails++; $display("FAIL next_frame_start: got offset %0d overrun %b expected 257 and 1", found, overrun);
    end
    t_frame = m_cyc - 1;
  endtask

  task automatic test_enable_drop();
    int ticks, done_d, held, wait_n;
    ticks = 0; done_d = -1; wait_n = -1;
    while (m_cyc - t_frame < 50) begin
      step(1'b1, 1'b1);
      checks++;
      if (act_v() !== model_v()) begin
        fails++; $display("FAIL pre_drop: got %h expected %h", act_v(), model_v());
      end
    end
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'b1);
      checks++;
      if (act_v() !== model_v()) begin
        fails++; $display("FAIL enable_low: got %h expected %h", act_v(), model_v());
      end
      if (sample_clk_en === 1'b1) ticks++;
      if (frame_done === 1'b1) done_d = m_cyc - t_frame;
    end
    checks++;
    if (ticks != 0 || done_d != 147) begin
      fails++; $display("FAIL enable_drop: ticks=%0d done=%0d expected 0/147", ticks, done_d);
    end
    held = m_div;
    for (int i = 1; i <= CLK_DIV + 1 && wait_n < 0; i++) begin
      step(1'b1, 1'b1);
      checks++;
      if (act_v() !== model_v()) begin
        fails++; $display("FAIL re_enable: got %h expected %h", act_v(), model_v());
      end
      if (sample_clk_en === 1'b1) wait_n = i;
    end
    checks++;
    if (wait_n != CLK_DIV - held) begin
      fails++; $display("FAIL resume_latency: got %0d expected %0d", wait_n, CLK_DIV - held);
    end
    t_frame = m_cyc;
  endtask

  task automatic test_reset_mid_frame();
    int dones;
    dones = 0;
    while (m_cyc - t_frame < 60) begin
      step(1'b1, 1'b1);
      checks++;
      if (act_v() !== model_v()) begin
        fails++; $display("FAIL pre_reset: got %h expected %h", act_v(), model_v());
      end
    end
    step(1'b1, 1'b0);
    checks++;
    if (act_v() !== '0) begin
      fails++; $display("FAIL mid_reset_outputs: got %h expected 0", act_v());
    end
    for (int i = 0; i < 120; i++) begin
      step(1'b1, 1'b1);
      checks++;
      if (act_v() !== model_v()) begin
        fails++; $display("FAIL post_reset: got %h expected %h", act_v(), model_v());
      end
      if (frame_done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      fails++; $display("FAIL aborted_frame_done: got %0d pulses expected 0", dones);
    end
  endtask

  task automatic test_random();
    logic en, rn;
    for (int i = 0; i < 2500; i++) begin
      en = ($urandom_range(0, 99) < 90);
      rn = ($urandom_range(0, 399) != 0);
      step(en, rn);
      checks++;
      if (act_v() !== model_v()) begin
        fails++; $display("FAIL random_cycle %0d: got %h expected %h", i, act_v(), model_v());
      end
`ifdef OPL3_FRAME_COUNTER_EN
      checks++;
      if (frame_count !== 16'(m_frames)) begin
        fails++; $display("FAIL frame_count: got %0d expected %0d", frame_count, m_frames & 16'hFFFF);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_overrun();
    test_enable_drop();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
